// File: rtl/bus_dest_loader.sv
// Destination side of the common-bus datapath: captures a bus word under a
// four-phase REQ/ACK handshake and loads, increments or clears one of R0-R3.
module bus_dest_loader #(
  parameter int size = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [size-1:0] BUS,
  input  logic            D0,
  input  logic            D1,
  input  logic [1:0]      OP,
  input  logic            LD_REQ,
  output logic            LD_ACK,
  output logic            BUSY,
  output logic [size-1:0] R0,
  output logic [size-1:0] R1,
  output logic [size-1:0] R2,
  output logic [size-1:0] R3,
  output logic            OVF,
  output logic            ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t          state_q, state_d;
  logic [size-1:0] bus_hold_q, bus_hold_d;
  logic [1:0]      dst_hold_q, dst_hold_d;
  logic [1:0]      op_hold_q, op_hold_d;
  logic [size-1:0] regs_q [4];
  logic [size-1:0] regs_d [4];
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [size-1:0] sel_val;
  logic [size-1:0] inc_val;
  logic [size-1:0] new_val;
  logic            sel_all_ones;
  logic            exec_write;
  logic [3:0]      wr_en;

  // Datapath operates only on the held copies, so bus/select changes after
  // capture cannot leak into the transfer in progress.
  always_comb begin
    sel_val      = regs_q[dst_hold_q];
    inc_val      = sel_val + {{(size-1){1'b0}}, 1'b1};
    sel_all_ones = &sel_val;
    exec_write   = (state_q == EXEC) && (op_hold_q != OP_RSVD);
    case (op_hold_q)
      OP_LOAD: new_val = bus_hold_q;
      OP_INC:  new_val = inc_val;
      default: new_val = '0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dst
      assign wr_en[gi] = exec_write && (dst_hold_q == 2'(gi));
      always_comb begin
        regs_d[gi] = wr_en[gi] ? new_val : regs_q[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    bus_hold_d = bus_hold_q;
    dst_hold_d = dst_hold_q;
    op_hold_d  = op_hold_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (LD_REQ) begin
          bus_hold_d = BUS;
          dst_hold_d = {D1, D0};
          op_hold_d  = OP;
          state_d    = EXEC;
          busy_d     = 1'b1;
          ack_d      = 1'b0;
        end
      end
      EXEC: begin
        state_d = DONE;
        ack_d   = 1'b1;
        busy_d  = 1'b1;
        if (op_hold_q == OP_INC && sel_all_ones) begin
          ovf_d = 1'b1;
        end
        if (op_hold_q == OP_RSVD) begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        if (!LD_REQ) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      bus_hold_q <= '0;
      dst_hold_q <= '0;
      op_hold_q  <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      bus_hold_q <= bus_hold_d;
      dst_hold_q <= dst_hold_d;
      op_hold_q  <= op_hold_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign LD_ACK = ack_q;
  assign BUSY   = busy_q;
  assign OVF    = ovf_q;
  assign ERR    = err_q;
  assign R0     = regs_q[0];
  assign R1     = regs_q[1];
  assign R2     = regs_q[2];
  assign R3     = regs_q[3];

endmodule
